// File: rtl/block_demux_rx.sv
// Receive demultiplexer: parses framed packets (header + PKT_LEN payload) and steers payload to FIFO 1..3.
// Optional macro CHKSUM_EN adds an XOR trailer byte checked in ST_CHK.
`ifndef BUFF_SIZE
`define BUFF_SIZE 7
`endif

module block_demux_rx #(
  parameter int         PKT_LEN    = 30,
  parameter int         CNT_W      = `BUFF_SIZE,
  parameter int         FIFO_DEPTH = 64,
  parameter logic [5:0] HDR_TAG    = 6'b101101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_vld,
  input  logic [CNT_W-1:0] f1_bf_cnt,
  input  logic [CNT_W-1:0] f2_bf_cnt,
  input  logic [CNT_W-1:0] f3_bf_cnt,
  output logic [7:0]       wr_data,
  output logic [2:0]       wr_en,
  output logic [1:0]       cur_cnl,
  output logic             pkt_done,
  output logic             hdr_err,
  output logic [7:0]       drop_cnt,
  output logic             chk_err
);

  localparam int BCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(PKT_LEN - 1);

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_PLD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

  logic [1:0]     state_reg;
  logic [BCW-1:0] byte_cnt_reg;
  logic [7:0]     wr_data_reg;
  logic [2:0]     wr_en_reg;
  logic [1:0]     cur_cnl_reg;
  logic           pkt_done_reg;
  logic           hdr_err_reg;
  logic [7:0]     drop_cnt_reg;
  logic           chk_err_reg;
`ifdef CHKSUM_EN
  logic [7:0]     chk_acc_reg;
  logic           chk_drop_reg;
`endif

  logic [CNT_W-1:0] occ [3];
  logic [2:0]       space_ok;
  logic [2:0]       cnl_hot;
  logic             hdr_ok;
  logic [1:0]       hdr_code;
  logic             code_space_ok;

  assign occ[0]   = f1_bf_cnt;
  assign occ[1]   = f2_bf_cnt;
  assign occ[2]   = f3_bf_cnt;
  assign hdr_ok   = (rx_data[7:2] == HDR_TAG);
  assign hdr_code = rx_data[1:0];

  // Space test rewritten as occ + PKT_LEN <= depth so it never underflows.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnl
      assign space_ok[gi] = ((32'(occ[gi]) + 32'(PKT_LEN)) <= 32'(FIFO_DEPTH));
      assign cnl_hot[gi]  = (cur_cnl_reg == 2'(gi + 1));
    end
  endgenerate

  always_comb begin
    code_space_ok = 1'b0;
    case (hdr_code)
      2'd1:    code_space_ok = space_ok[0];
      2'd2:    code_space_ok = space_ok[1];
      2'd3:    code_space_ok = space_ok[2];
      default: code_space_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_HDR;
      byte_cnt_reg <= '0;
      wr_data_reg  <= 8'h00;
      wr_en_reg    <= 3'b000;
      cur_cnl_reg  <= 2'd0;
      pkt_done_reg <= 1'b0;
      hdr_err_reg  <= 1'b0;
      drop_cnt_reg <= 8'h00;
      chk_err_reg  <= 1'b0;
`ifdef CHKSUM_EN
      chk_acc_reg  <= 8'h00;
      chk_drop_reg <= 1'b0;
`endif
    end else begin
      wr_en_reg    <= 3'b000;
      pkt_done_reg <= 1'b0;
      hdr_err_reg  <= 1'b0;
      chk_err_reg  <= 1'b0;
      if (rx_vld) begin
        case (state_reg)
          ST_HDR: begin
            if (!hdr_ok) begin
              hdr_err_reg <= 1'b1;
            end else begin
              cur_cnl_reg  <= hdr_code;
              byte_cnt_reg <= '0;
`ifdef CHKSUM_EN
              chk_acc_reg  <= rx_data;
`endif
              if (hdr_code == 2'd0) begin
                state_reg <= ST_DROP;
              end else if (code_space_ok) begin
                state_reg <= ST_PLD;
              end else begin
                state_reg <= ST_DROP;
                if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
              end
            end
          end
          ST_PLD, ST_DROP: begin
            if (state_reg == ST_PLD) begin
              wr_data_reg <= rx_data;
              wr_en_reg   <= cnl_hot;
            end
`ifdef CHKSUM_EN
            chk_acc_reg <= chk_acc_reg ^ rx_data;
`endif
            if (byte_cnt_reg == LAST_IDX) begin
              byte_cnt_reg <= '0;
              cur_cnl_reg  <= 2'd0;
`ifdef CHKSUM_EN
              state_reg    <= ST_CHK;
              chk_drop_reg <= (state_reg == ST_DROP);
`else
              state_reg    <= ST_HDR;
              pkt_done_reg <= 1'b1;
`endif
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
          ST_CHK: begin
`ifdef CHKSUM_EN
            // Dropped packets still eat their trailer but never flag it.
            pkt_done_reg <= 1'b1;
            chk_err_reg  <= !chk_drop_reg && (rx_data != chk_acc_reg);
`endif
            state_reg <= ST_HDR;
          end
        endcase
      end
    end
  end

  assign wr_data  = wr_data_reg;
  assign wr_en    = wr_en_reg;
  assign cur_cnl  = cur_cnl_reg;
  assign pkt_done = pkt_done_reg;
  assign hdr_err  = hdr_err_reg;
  assign drop_cnt = drop_cnt_reg;
  assign chk_err  = chk_err_reg;

endmodule

// File: tb/tb_block_demux_rx.sv
// Directed self-checking bench for block_demux_rx; inputs change on negedge, outputs checked on the next negedge.
`timescale 1ns/1ps

module tb_block_demux_rx;

  localparam int PKT_LEN = 30;
  localparam int CNT_W   = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_vld = 1'b0;
  logic [CNT_W-1:0] f1_bf_cnt = '0;
  logic [CNT_W-1:0] f2_bf_cnt = '0;
  logic [CNT_W-1:0] f3_bf_cnt = '0;
  logic [7:0]       wr_data;
  logic [2:0]       wr_en;
  logic [1:0]       cur_cnl;
  logic             pkt_done;
  logic             hdr_err;
  logic [7:0]       drop_cnt;
  logic             chk_err;

  int checks = 0;
  int errors = 0;

  block_demux_rx #(
    .PKT_LEN(PKT_LEN), .CNT_W(CNT_W), .FIFO_DEPTH(64), .HDR_TAG(6'b101101)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
    .f1_bf_cnt(f1_bf_cnt), .f2_bf_cnt(f2_bf_cnt), .f3_bf_cnt(f3_bf_cnt),
    .wr_data(wr_data), .wr_en(wr_en), .cur_cnl(cur_cnl), .pkt_done(pkt_done),
    .hdr_err(hdr_err), .drop_cnt(drop_cnt), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic idle();
    rx_vld = 1'b0;
    @(negedge clk);
  endtask

  // One framed packet with per-byte checks; exp_en is the expected write strobe (0 when discarded).
  task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] base, input logic [2:0] exp_en,
                         input bit gaps, input bit bad_chk, input logic [7:0] exp_drop);
    logic [7:0] acc;
    logic [7:0] b;
    logic       exp_done;
    acc = hdr;
    send(hdr);
    checks++;
    if (cur_cnl !== hdr[1:0] || wr_en !== 3'b000 || drop_cnt !== exp_drop || hdr_err !== 1'b0) begin
      errors++;
      $display("FAIL hdr %h: cur_cnl=%0d wr_en=%b drop_cnt=%0d hdr_err=%b, want %0d 000 %0d 0",
               hdr, cur_cnl, wr_en, drop_cnt, hdr_err, hdr[1:0], exp_drop);
    end
    for (int i = 0; i < PKT_LEN; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        idle();
        checks++;
        if (wr_en !== 3'b000 || pkt_done !== 1'b0) begin
          errors++;
          $display("FAIL gap: wr_en=%b pkt_done=%b, want 000 0", wr_en, pkt_done);
        end
      end
      b = base + 8'(i);
      acc = acc ^ b;
      send(b);
`ifdef CHKSUM_EN
      exp_done = 1'b0;
`else
      exp_done = (i == PKT_LEN - 1);
`endif
      checks++;
      if (wr_en !== exp_en || (exp_en != 3'b000 && wr_data !== b) || pkt_done !== exp_done) begin
        errors++;
        $display("FAIL pld hdr=%h i=%0d: wr_en=%b wr_data=%h pkt_done=%b, want %b %h %b",
                 hdr, i, wr_en, wr_data, pkt_done, exp_en, b, exp_done);
      end
    end
    checks++;
    if (cur_cnl !== 2'd0) begin
      errors++;
      $display("FAIL end_cnl hdr=%h: cur_cnl=%0d, want 0", hdr, cur_cnl);
    end
`ifdef CHKSUM_EN
    send(bad_chk ? (acc ^ 8'h01) : acc);
    checks++;
    if (pkt_done !== 1'b1 || chk_err !== (bad_chk && exp_en != 3'b000) || wr_en !== 3'b000) begin
      errors++;
      $display("FAIL trailer hdr=%h: pkt_done=%b chk_err=%b wr_en=%b, want 1 %b 000",
               hdr, pkt_done, chk_err, wr_en, (bad_chk && exp_en != 3'b000));
    end
`else
    checks++;
    if (chk_err !== 1'b0 || bad_chk) begin
      errors++;
      $display("FAIL chk_err: chk_err=%b, want 0", chk_err);
    end
`endif
    $display("pkt hdr=%h base=%h wr_en=%b drop_cnt=%0d", hdr, base, exp_en, drop_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    checks++;
    if (wr_en !== 3'b000 || wr_data !== 8'h00 || cur_cnl !== 2'd0 || pkt_done !== 1'b0 ||
        hdr_err !== 1'b0 || drop_cnt !== 8'h00 || chk_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: wr_en=%b wr_data=%h cur_cnl=%0d pkt_done=%b hdr_err=%b drop_cnt=%0d chk_err=%b, want all 0",
               wr_en, wr_data, cur_cnl, pkt_done, hdr_err, drop_cnt, chk_err);
    end
    $display("reset done");
  endtask

  task automatic test_route_ch1();
    f1_bf_cnt = 7'd0;
    run_pkt(8'hB5, 8'h00, 3'b001, 1'b0, 1'b0, 8'd0);
    idle();
    checks++;
    if (pkt_done !== 1'b0 || wr_en !== 3'b000) begin
      errors++;
      $display("FAIL pulse_clear: pkt_done=%b wr_en=%b, want 0 000", pkt_done, wr_en);
    end
  endtask

  task automatic test_code0();
    run_pkt(8'hB4, 8'h40, 3'b000, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_hdr_err();
    send(8'h00);
    checks++;
    if (hdr_err !== 1'b1 || cur_cnl !== 2'd0 || wr_en !== 3'b000) begin
      errors++;
      $display("FAIL hdr_err: hdr_err=%b cur_cnl=%0d wr_en=%b, want 1 0 000", hdr_err, cur_cnl, wr_en);
    end
    idle();
    checks++;
    if (hdr_err !== 1'b0) begin
      errors++;
      $display("FAIL hdr_err_pulse: hdr_err=%b, want 0", hdr_err);
    end
    f2_bf_cnt = 7'd34;  // free space exactly 30: accepted
    run_pkt(8'hB6, 8'h80, 3'b010, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_drop();
    logic [7:0] exp;
    f3_bf_cnt = 7'd40;
    for (int k = 1; k <= 300; k++) begin
      exp = (k > 255) ? 8'd255 : 8'(k);
      run_pkt(8'hB7, 8'h10, 3'b000, 1'b0, 1'b0, exp);
    end
  endtask

  task automatic test_back_to_back();
    f1_bf_cnt = 7'd10;
    f2_bf_cnt = 7'd0;
    f3_bf_cnt = 7'd0;
    run_pkt(8'hB5, 8'h20, 3'b001, 1'b1, 1'b0, 8'd255);
    run_pkt(8'hB6, 8'h60, 3'b010, 1'b1, 1'b0, 8'd255);
    run_pkt(8'hB7, 8'hA0, 3'b100, 1'b1, 1'b0, 8'd255);
  endtask

  task automatic test_reset_mid_packet();
    send(8'hB6);
    for (int i = 0; i < 10; i++) send(8'hC0 + 8'(i));
    rx_data = 8'hCA;
    rx_vld  = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
    rst     = 1'b0;
    checks++;
    if (wr_en !== 3'b000 || cur_cnl !== 2'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst: wr_en=%b cur_cnl=%0d drop_cnt=%0d, want 000 0 0", wr_en, cur_cnl, drop_cnt);
    end
    run_pkt(8'hB5, 8'hD0, 3'b001, 1'b0, 1'b0, 8'd0);
  endtask

`ifdef CHKSUM_EN
  task automatic test_chksum();
    f1_bf_cnt = 7'd0;
    f3_bf_cnt = 7'd40;
    run_pkt(8'hB5, 8'h05, 3'b001, 1'b0, 1'b0, 8'd0);
    run_pkt(8'hB5, 8'h33, 3'b001, 1'b0, 1'b1, 8'd0);
    run_pkt(8'hB7, 8'h44, 3'b000, 1'b0, 1'b1, 8'd1);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_route_ch1();
    test_code0();
    test_hdr_err();
    test_drop();
    test_back_to_back();
    test_reset_mid_packet();
`ifdef CHKSUM_EN
    test_chksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_demux_rx.md
Name: block_demux_rx

Overview:
- Receive-side counterpart of the transmit arbiter.
- Accepts the serial byte stream of framed packets: one header byte carrying the 2-bit channel code, then PKT_LEN payload bytes.
- Routes the payload of code 1/2/3 packets into the matching output FIFO and discards code-0 (empty) packets.
- Sits between the link deserializer and the three receive FIFOs.

Parameters:
- PKT_LEN, 30, payload bytes per packet (header excluded).
- CNT_W, `BUFF_SIZE, width of the downstream FIFO occupancy inputs.
- FIFO_DEPTH, 64, depth of each downstream FIFO; free space = FIFO_DEPTH - f*_bf_cnt.
- HDR_TAG, 6'b101101, required value of header bits [7:2].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte
- rx_vld  in  1  rx_data valid this cycle; one byte per asserted cycle, no backpressure
- f1_bf_cnt  in  CNT_W  occupancy of FIFO 1
- f2_bf_cnt  in  CNT_W  occupancy of FIFO 2
- f3_bf_cnt  in  CNT_W  occupancy of FIFO 3
- wr_data  out  8  payload byte to the FIFOs
- wr_en  out  3  one-hot write strobe; bit0 = FIFO 1, bit1 = FIFO 2, bit2 = FIFO 3
- cur_cnl  out  2  channel code of the packet in progress (0 when idle)
- pkt_done  out  1  one-cycle pulse after the last payload byte of any packet, dropped packets included
- hdr_err  out  1  one-cycle pulse on a byte with a bad header tag
- drop_cnt  out  8  saturating count of non-empty packets dropped for lack of FIFO space
- chk_err  out  1  checksum mismatch pulse (CHKSUM_EN only; tied 0 otherwise)

Behaviour:
- Reset (synchronous, active-high):
  - state=ST_HDR; wr_en=0, wr_data=0, cur_cnl=0, pkt_done=0, hdr_err=0, drop_cnt=0, chk_err=0; byte counter=0.
  - Reset mid-packet abandons the packet; no further writes; the next byte is parsed as a header.
- Cycles with rx_vld=0 change nothing except clearing the pulse outputs.
- All outputs are registered; each pulse lasts exactly one cycle.
- ST_HDR, on rx_vld:
  - rx_data[7:2]!=HDR_TAG: hdr_err=1 next cycle; byte discarded; stay in ST_HDR.
  - Code 0: cur_cnl<=0; go to ST_DROP; drop_cnt unchanged.
  - Code n=1..3 with FIFO_DEPTH - fn_bf_cnt >= PKT_LEN, sampled on the header cycle: cur_cnl<=n; go to ST_PLD.
  - Code n=1..3 with insufficient space: cur_cnl<=n; go to ST_DROP; drop_cnt+1, saturating at 255.
- ST_PLD, on rx_vld:
  - Next cycle: wr_data=rx_data, wr_en bit (cur_cnl-1)=1. Latency is 1 cycle from byte to write.
  - Byte counter counts 0..PKT_LEN-1.
  - On byte PKT_LEN-1: pkt_done=1 next cycle (coincides with the last wr_en); go to ST_HDR (or ST_CHK), cur_cnl<=0.
- ST_DROP: same counting as ST_PLD with wr_en held 0; pkt_done on the last byte; then ST_HDR (or ST_CHK).
- A header arriving the cycle after the last payload byte is accepted; back-to-back packets need no idle gap.
- The space check is made once per packet only. FIFO overflow mid-packet is impossible by construction and not checked.
- Byte counter width is clog2(PKT_LEN); it resets to 0 on every header accept.

Optional Feature:
- Macro: CHKSUM_EN.
- Defined:
  - After the payload, one trailer byte equal to the XOR of the header and all payload bytes.
  - State ST_CHK consumes it, compares, and pulses chk_err=1 on mismatch, then returns to ST_HDR.
  - pkt_done fires after the trailer, not after the last payload byte.
  - Already-written payload is not retracted. Dropped packets also consume their trailer; their chk_err is suppressed.
- Undefined: no trailer byte, no ST_CHK; chk_err constant 0.

Test Plan:
- Reset, then header 8'hB5 (tag ok, code 1), f1_bf_cnt=0, 30 bytes 0x00..0x1D -> wr_en=3'b001 for 30 cycles, wr_data 0x00..0x1D each one cycle after input, pkt_done coincident with the last write, drop_cnt=0.
- Header 8'hB4 (code 0) + 30 bytes -> no wr_en, pkt_done after byte 30, drop_cnt=0.
- Header 8'hB7 (code 3) with f3_bf_cnt=40 (free 24 < 30) -> no writes, drop_cnt=1, pkt_done after byte 30; repeated 300 times -> drop_cnt=255.
- Byte 8'h00 in ST_HDR -> hdr_err pulse; following 8'hB6 + 30 bytes -> wr_en=3'b010 ×30.
- Back-to-back packets codes 1,2,3 with no idle gap and rx_vld gapped randomly inside payloads -> 30 writes per FIFO in order; rst asserted at payload byte 10 of a code-2 packet -> writes stop, next byte is parsed as a header.
- CHKSUM_EN: correct trailer -> chk_err=0; trailer XOR 8'h01 -> chk_err pulse; pkt_done after the trailer.
